// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and the burst master sequencing states.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StAw,
        StW,
        StB,
        StAr,
        StR,
        StDone
    } state_e;

    // AxSIZE encoding for a full-width beat of the given data bus width.
    function automatic logic [2:0] size_from_width(input int unsigned width);
        int unsigned bytes;
        logic [2:0]  size;
        bytes = width / 8;
        size  = 3'd0;
        for (int unsigned i = 0; i < 8; i++) begin
            if ((32'd1 << i) == bytes) begin
                size = 3'(i);
            end
        end
        return size;
    endfunction

endpackage

// File: rtl/axi_beat_pattern.sv
// Beat counter with seed+index pattern, last-beat flag and saturating mismatch counter.
module axi_beat_pattern #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned BurstLen  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clr_i,
    input  logic                 adv_i,
    input  logic                 check_i,
    input  logic [DataWidth-1:0] seed_i,
    input  logic [DataWidth-1:0] data_i,
    output logic [DataWidth-1:0] data_o,
    output logic                 last_o,
    output logic                 mismatch_o,
    output logic [7:0]           err_cnt_o
);

    localparam logic [8:0] LastIdx = 9'(BurstLen - 1);

    logic [8:0] cnt_q, cnt_d;
    logic [7:0] err_q, err_d;

    assign data_o     = seed_i + DataWidth'(cnt_q);
    assign last_o     = (cnt_q == LastIdx);
    assign mismatch_o = check_i & adv_i & (data_i != data_o);
    assign err_cnt_o  = err_q;

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (clr_i) begin
            cnt_d = '0;
            err_d = '0;
        end else begin
            if (adv_i) begin
                cnt_d = last_o ? 9'd0 : cnt_q + 9'd1;
            end
            if (mismatch_o && (err_q != 8'hFF)) begin
                err_d = err_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            err_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

endmodule

// File: rtl/axi_burst_master.sv
// AXI4 traffic generator: writes one seed+index INCR burst, reads it back and checks each beat.
module axi_burst_master
    import axi_pkg::*;
#(
    parameter logic [63:0] C_M_TARGET_BASE_ADDR = 64'h0,
    parameter int unsigned C_M_AXI_BURST_LEN    = 16,
    parameter int unsigned C_M_AXI_ID_WIDTH     = 1,
    parameter int unsigned C_M_AXI_ADDR_WIDTH   = 32,
    parameter int unsigned C_M_AXI_DATA_WIDTH   = 32,
    parameter int unsigned C_M_AXI_AWUSER_WIDTH = 1,
    parameter int unsigned C_M_AXI_ARUSER_WIDTH = 1,
    parameter int unsigned C_M_AXI_WUSER_WIDTH  = 1,
    parameter int unsigned C_M_AXI_RUSER_WIDTH  = 1,
    parameter int unsigned C_M_AXI_BUSER_WIDTH  = 1
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESET,
    input  logic                              i_start,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     i_seed,
    output logic                              o_busy,
    output logic                              o_done,
    output logic                              o_error,
    output logic [7:0]                        o_err_cnt,
    output logic [C_M_AXI_ID_WIDTH-1:0]       M_AXI_AWID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [7:0]                        M_AXI_AWLEN,
    output logic [2:0]                        M_AXI_AWSIZE,
    output logic [1:0]                        M_AXI_AWBURST,
    output logic                              M_AXI_AWLOCK,
    output logic [3:0]                        M_AXI_AWCACHE,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic [3:0]                        M_AXI_AWQOS,
    output logic [3:0]                        M_AXI_AWREGION,
    output logic [C_M_AXI_AWUSER_WIDTH-1:0]   M_AXI_AWUSER,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WLAST,
    output logic [C_M_AXI_WUSER_WIDTH-1:0]    M_AXI_WUSER,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [C_M_AXI_ID_WIDTH-1:0]       M_AXI_BID,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic [C_M_AXI_BUSER_WIDTH-1:0]    M_AXI_BUSER,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ID_WIDTH-1:0]       M_AXI_ARID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [7:0]                        M_AXI_ARLEN,
    output logic [2:0]                        M_AXI_ARSIZE,
    output logic [1:0]                        M_AXI_ARBURST,
    output logic                              M_AXI_ARLOCK,
    output logic [3:0]                        M_AXI_ARCACHE,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic [3:0]                        M_AXI_ARQOS,
    output logic [3:0]                        M_AXI_ARREGION,
    output logic [C_M_AXI_ARUSER_WIDTH-1:0]   M_AXI_ARUSER,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_ID_WIDTH-1:0]       M_AXI_RID,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RLAST,
    input  logic [C_M_AXI_RUSER_WIDTH-1:0]    M_AXI_RUSER,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    localparam int unsigned Dw     = C_M_AXI_DATA_WIDTH;
    localparam logic [7:0]  AxLen  = 8'(C_M_AXI_BURST_LEN - 1);
    localparam logic [2:0]  AxSize = size_from_width(C_M_AXI_DATA_WIDTH);

    state_e         state_q, state_d;
    logic [Dw-1:0]  seed_q, seed_d;
    logic           error_q, error_d;

    logic           start_acc;
    logic           w_hs, r_hs;
    logic [Dw-1:0]  w_data, r_exp, w_dummy_in;
    logic           w_last, r_last, r_mismatch, w_mismatch;
    logic [7:0]     w_err_cnt;

    assign start_acc  = (state_q == StIdle) & i_start;
    assign w_hs       = M_AXI_WVALID & M_AXI_WREADY;
    assign r_hs       = M_AXI_RVALID & M_AXI_RREADY;
    assign w_dummy_in = '0;

    axi_beat_pattern #(
        .DataWidth (Dw),
        .BurstLen  (C_M_AXI_BURST_LEN)
    ) u_w_pattern (
        .clk_i      (M_AXI_ACLK),
        .rst_i      (M_AXI_ARESET),
        .clr_i      (start_acc),
        .adv_i      (w_hs),
        .check_i    (1'b0),
        .seed_i     (seed_q),
        .data_i     (w_dummy_in),
        .data_o     (w_data),
        .last_o     (w_last),
        .mismatch_o (w_mismatch),
        .err_cnt_o  (w_err_cnt)
    );

    axi_beat_pattern #(
        .DataWidth (Dw),
        .BurstLen  (C_M_AXI_BURST_LEN)
    ) u_r_pattern (
        .clk_i      (M_AXI_ACLK),
        .rst_i      (M_AXI_ARESET),
        .clr_i      (start_acc),
        .adv_i      (r_hs),
        .check_i    (1'b1),
        .seed_i     (seed_q),
        .data_i     (M_AXI_RDATA),
        .data_o     (r_exp),
        .last_o     (r_last),
        .mismatch_o (r_mismatch),
        .err_cnt_o  (o_err_cnt)
    );

    logic unused_sigs;
    assign unused_sigs = ^{M_AXI_BID, M_AXI_BUSER, M_AXI_RID, M_AXI_RUSER, r_exp,
                           w_mismatch, w_err_cnt};

    assign M_AXI_AWID     = '0;
    assign M_AXI_AWADDR   = C_M_TARGET_BASE_ADDR[C_M_AXI_ADDR_WIDTH-1:0];
    assign M_AXI_AWLEN    = AxLen;
    assign M_AXI_AWSIZE   = AxSize;
    assign M_AXI_AWBURST  = BURST_INCR;
    assign M_AXI_AWLOCK   = 1'b0;
    assign M_AXI_AWCACHE  = 4'b0010;
    assign M_AXI_AWPROT   = 3'b000;
    assign M_AXI_AWQOS    = 4'b0000;
    assign M_AXI_AWREGION = 4'b0000;
    assign M_AXI_AWUSER   = '0;
    assign M_AXI_ARID     = '0;
    assign M_AXI_ARADDR   = C_M_TARGET_BASE_ADDR[C_M_AXI_ADDR_WIDTH-1:0];
    assign M_AXI_ARLEN    = AxLen;
    assign M_AXI_ARSIZE   = AxSize;
    assign M_AXI_ARBURST  = BURST_INCR;
    assign M_AXI_ARLOCK   = 1'b0;
    assign M_AXI_ARCACHE  = 4'b0010;
    assign M_AXI_ARPROT   = 3'b000;
    assign M_AXI_ARQOS    = 4'b0000;
    assign M_AXI_ARREGION = 4'b0000;
    assign M_AXI_ARUSER   = '0;
    assign M_AXI_WSTRB    = '1;
    assign M_AXI_WUSER    = '0;
    assign M_AXI_WDATA    = w_data;
    assign o_error        = error_q;

    // All handshake outputs decode straight from the state register so reset drops them at once.
    always_comb begin
        state_d       = state_q;
        seed_d        = start_acc ? i_seed : seed_q;
        error_d       = error_q;
        M_AXI_AWVALID = 1'b0;
        M_AXI_WVALID  = 1'b0;
        M_AXI_WLAST   = 1'b0;
        M_AXI_BREADY  = 1'b0;
        M_AXI_ARVALID = 1'b0;
        M_AXI_RREADY  = 1'b0;
        o_busy        = 1'b1;
        o_done        = 1'b0;

        unique case (state_q)
            StIdle: begin
                o_busy = 1'b0;
                if (i_start) begin
                    state_d = StAw;
                    error_d = 1'b0;
                end
            end
            StAw: begin
                M_AXI_AWVALID = 1'b1;
                if (M_AXI_AWREADY) state_d = StW;
            end
            StW: begin
                M_AXI_WVALID = 1'b1;
                M_AXI_WLAST  = w_last;
                if (M_AXI_WREADY && w_last) state_d = StB;
            end
            StB: begin
                M_AXI_BREADY = 1'b1;
                if (M_AXI_BVALID) begin
                    state_d = StAr;
                    if (M_AXI_BRESP != RESP_OKAY) error_d = 1'b1;
                end
            end
            StAr: begin
                M_AXI_ARVALID = 1'b1;
                if (M_AXI_ARREADY) state_d = StR;
            end
            StR: begin
                M_AXI_RREADY = 1'b1;
                if (M_AXI_RVALID) begin
                    if ((M_AXI_RRESP != RESP_OKAY) || r_mismatch || (M_AXI_RLAST && !r_last)) begin
                        error_d = 1'b1;
                    end
                    // Beat count, not RLAST, closes the read phase.
                    if (r_last) state_d = StDone;
                end
            end
            StDone: begin
                o_busy  = 1'b0;
                o_done  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            state_q <= StIdle;
            seed_q  <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            seed_q  <= seed_d;
            error_q <= error_d;
        end
    end

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench: reactive AXI RAM slave for a 16-beat master plus a hand-driven 1-beat master.
module tb_axi_burst_master;

    localparam int Len = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] seed = '0;
    logic        busy, done, error;
    logic [7:0]  err_cnt;
    logic [0:0]  awid, arid;
    logic [31:0] awaddr, araddr, wdata;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, awprot, arsize, arprot;
    logic [1:0]  awburst, arburst;
    logic        awlock, arlock, awvalid, arvalid, wvalid, wlast, bready, rready;
    logic [3:0]  awcache, awqos, awregion, arcache, arqos, arregion, wstrb;
    logic [0:0]  awuser, aruser, wuser;
    logic        awready = 1'b0, wready = 1'b0, arready = 1'b0;
    logic        bvalid = 1'b0, rvalid = 1'b0, rlast = 1'b0;
    logic [1:0]  bresp = 2'b00, rresp = 2'b00;
    logic [31:0] rdata = '0;

    logic        start1 = 1'b0;
    logic [31:0] seed1 = '0;
    logic        busy1, done1, error1;
    logic [7:0]  err_cnt1;
    logic [0:0]  awid1, arid1;
    logic [31:0] awaddr1, araddr1, wdata1;
    logic [7:0]  awlen1, arlen1;
    logic [2:0]  awsize1, awprot1, arsize1, arprot1;
    logic [1:0]  awburst1, arburst1;
    logic        awlock1, arlock1, awvalid1, arvalid1, wvalid1, wlast1, bready1, rready1;
    logic [3:0]  awcache1, awqos1, awregion1, arcache1, arqos1, arregion1, wstrb1;
    logic [0:0]  awuser1, aruser1, wuser1;
    logic        bvalid1 = 1'b0, rvalid1 = 1'b0, rlast1 = 1'b0;
    logic [1:0]  bresp1 = 2'b00;
    logic [31:0] rdata1 = '0;
    logic [0:0]  zero_id = '0, zero_user = '0;

    axi_burst_master #(.C_M_AXI_BURST_LEN(Len)) u_dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESET(rst), .i_start(start), .i_seed(seed),
        .o_busy(busy), .o_done(done), .o_error(error), .o_err_cnt(err_cnt),
        .M_AXI_AWID(awid), .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
        .M_AXI_AWBURST(awburst), .M_AXI_AWLOCK(awlock), .M_AXI_AWCACHE(awcache),
        .M_AXI_AWPROT(awprot), .M_AXI_AWQOS(awqos), .M_AXI_AWREGION(awregion),
        .M_AXI_AWUSER(awuser), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast), .M_AXI_WUSER(wuser),
        .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BID(zero_id), .M_AXI_BRESP(bresp), .M_AXI_BUSER(zero_user),
        .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARID(arid), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
        .M_AXI_ARBURST(arburst), .M_AXI_ARLOCK(arlock), .M_AXI_ARCACHE(arcache),
        .M_AXI_ARPROT(arprot), .M_AXI_ARQOS(arqos), .M_AXI_ARREGION(arregion),
        .M_AXI_ARUSER(aruser), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RID(zero_id), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast),
        .M_AXI_RUSER(zero_user), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    axi_burst_master #(.C_M_AXI_BURST_LEN(1)) u_dut1 (
        .M_AXI_ACLK(clk), .M_AXI_ARESET(rst), .i_start(start1), .i_seed(seed1),
        .o_busy(busy1), .o_done(done1), .o_error(error1), .o_err_cnt(err_cnt1),
        .M_AXI_AWID(awid1), .M_AXI_AWADDR(awaddr1), .M_AXI_AWLEN(awlen1),
        .M_AXI_AWSIZE(awsize1), .M_AXI_AWBURST(awburst1), .M_AXI_AWLOCK(awlock1),
        .M_AXI_AWCACHE(awcache1), .M_AXI_AWPROT(awprot1), .M_AXI_AWQOS(awqos1),
        .M_AXI_AWREGION(awregion1), .M_AXI_AWUSER(awuser1), .M_AXI_AWVALID(awvalid1),
        .M_AXI_AWREADY(1'b1),
        .M_AXI_WDATA(wdata1), .M_AXI_WSTRB(wstrb1), .M_AXI_WLAST(wlast1),
        .M_AXI_WUSER(wuser1), .M_AXI_WVALID(wvalid1), .M_AXI_WREADY(1'b1),
        .M_AXI_BID(zero_id), .M_AXI_BRESP(bresp1), .M_AXI_BUSER(zero_user),
        .M_AXI_BVALID(bvalid1), .M_AXI_BREADY(bready1),
        .M_AXI_ARID(arid1), .M_AXI_ARADDR(araddr1), .M_AXI_ARLEN(arlen1),
        .M_AXI_ARSIZE(arsize1), .M_AXI_ARBURST(arburst1), .M_AXI_ARLOCK(arlock1),
        .M_AXI_ARCACHE(arcache1), .M_AXI_ARPROT(arprot1), .M_AXI_ARQOS(arqos1),
        .M_AXI_ARREGION(arregion1), .M_AXI_ARUSER(aruser1), .M_AXI_ARVALID(arvalid1),
        .M_AXI_ARREADY(1'b1),
        .M_AXI_RID(zero_id), .M_AXI_RDATA(rdata1), .M_AXI_RRESP(2'b00), .M_AXI_RLAST(rlast1),
        .M_AXI_RUSER(zero_user), .M_AXI_RVALID(rvalid1), .M_AXI_RREADY(rready1)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Slave model state; cur_seed is the pattern the bench expects the master to write.
    logic [31:0] mem [16];
    logic [31:0] cur_seed = '0;
    logic [15:0] corrupt = '0;
    logic [1:0]  bresp_cfg = 2'b00;
    logic        bp = 1'b0;
    logic        b_go = 1'b0, b_hs = 1'b0, r_hs = 1'b0, r_active = 1'b0;
    int          wbeat = 0, rbeat = 0, rlen = 0, n_wlast = 0, n_done = 0;

    // Runs on the falling edge: retire last rising-edge handshakes, drive, then pre-evaluate.
    task automatic slave_step();
        if (rst) begin
            awready = 1'b0; wready = 1'b0; arready = 1'b0;
            bvalid = 1'b0; rvalid = 1'b0; rlast = 1'b0;
            wbeat = 0; rbeat = 0; r_active = 1'b0; b_go = 1'b0; b_hs = 1'b0; r_hs = 1'b0;
            return;
        end
        if (b_hs) bvalid = 1'b0;
        if (r_hs) begin
            rvalid = 1'b0;
            rbeat++;
            if (rbeat > rlen) r_active = 1'b0;
        end
        if (b_go) begin
            bvalid = 1'b1; bresp = bresp_cfg; b_go = 1'b0;
        end
        if (r_active && !rvalid && (!bp || $urandom_range(0, 1) == 1)) begin
            rvalid = 1'b1;
            rdata  = mem[4'(rbeat)] ^ (corrupt[4'(rbeat)] ? 32'h8000_0001 : 32'h0);
            rlast  = (rbeat == rlen);
            rresp  = 2'b00;
        end
        awready = !bp || ($urandom_range(0, 1) == 1);
        wready  = !bp || ($urandom_range(0, 1) == 1);
        arready = !bp || ($urandom_range(0, 1) == 1);
        if (awvalid) begin
            check("awaddr", awaddr, 32'h0);
            check("awlen", {24'h0, awlen}, 32'(Len - 1));
            if (awready) wbeat = 0;
        end
        if (wvalid) begin
            check("wdata", wdata, cur_seed + 32'(wbeat));
            check("wlast", {31'h0, wlast}, {31'h0, wbeat == Len - 1});
            if (wready) begin
                mem[4'(wbeat)] = wdata;
                if (wlast) begin
                    n_wlast++;
                    b_go = 1'b1;
                end
                wbeat++;
            end
        end
        if (arvalid) begin
            check("araddr", araddr, 32'h0);
            check("arlen", {24'h0, arlen}, 32'(Len - 1));
            if (arready) begin
                rlen = int'(arlen); rbeat = 0; r_active = 1'b1;
            end
        end
        b_hs = bvalid && bready;
        r_hs = rvalid && rready;
    endtask

    initial forever begin
        @(negedge clk);
        slave_step();
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (done) n_done++;
    end

    task automatic run_seq(input string tag, input logic [31:0] s, input logic bpx,
                           input logic [15:0] cor, input logic [1:0] br,
                           input logic exp_err, input logic [7:0] exp_cnt);
        int d0;
        bit seen;
        cur_seed = s; bp = bpx; corrupt = cor; bresp_cfg = br; n_wlast = 0;
        d0 = n_done;
        @(negedge clk);
        start = 1'b1; seed = s;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy"}, {31'h0, busy}, 32'h1);
        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        check({tag, "_done_seen"}, {31'h0, seen}, 32'h1);
        check({tag, "_busy_at_done"}, {31'h0, busy}, 32'h0);
        check({tag, "_error"}, {31'h0, error}, {31'h0, exp_err});
        check({tag, "_err_cnt"}, {24'h0, err_cnt}, {24'h0, exp_cnt});
        @(negedge clk);
        check({tag, "_wbeats"}, wbeat, Len);
        check({tag, "_wlast_cnt"}, n_wlast, 1);
        check({tag, "_rbeats"}, rbeat, Len);
        check({tag, "_done_pulses"}, n_done - d0, 1);
        check({tag, "_idle"}, {31'h0, busy}, 32'h0);
    endtask

    task automatic run_len1();
        logic [31:0] s1;
        s1 = 32'hABCD_0123;
        @(negedge clk);
        start1 = 1'b1; seed1 = s1;
        @(negedge clk);
        start1 = 1'b0;
        check("len1_awvalid", {31'h0, awvalid1}, 32'h1);
        check("len1_awlen", {24'h0, awlen1}, 32'h0);
        @(negedge clk);
        check("len1_wvalid", {31'h0, wvalid1}, 32'h1);
        check("len1_wdata", wdata1, s1);
        check("len1_wlast", {31'h0, wlast1}, 32'h1);
        @(negedge clk);
        check("len1_w_dropped", {31'h0, wvalid1}, 32'h0);
        check("len1_bready", {31'h0, bready1}, 32'h1);
        bvalid1 = 1'b1; bresp1 = 2'b00;
        @(negedge clk);
        bvalid1 = 1'b0;
        check("len1_arvalid", {31'h0, arvalid1}, 32'h1);
        check("len1_arlen", {24'h0, arlen1}, 32'h0);
        @(negedge clk);
        check("len1_rready", {31'h0, rready1}, 32'h1);
        rvalid1 = 1'b1; rdata1 = s1; rlast1 = 1'b1;
        @(negedge clk);
        rvalid1 = 1'b0; rlast1 = 1'b0;
        check("len1_done", {31'h0, done1}, 32'h1);
        check("len1_error", {31'h0, error1}, 32'h0);
        check("len1_err_cnt", {24'h0, err_cnt1}, 32'h0);
        check("len1_rready_off", {31'h0, rready1}, 32'h0);
    endtask

    initial begin
        int d0;
        bit seen;
        repeat (3) @(negedge clk);
        check("rst_awvalid", {31'h0, awvalid}, 32'h0);
        check("rst_wvalid", {31'h0, wvalid}, 32'h0);
        check("rst_wlast", {31'h0, wlast}, 32'h0);
        check("rst_wdata", wdata, 32'h0);
        check("rst_bready", {31'h0, bready}, 32'h0);
        check("rst_arvalid", {31'h0, arvalid}, 32'h0);
        check("rst_rready", {31'h0, rready}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_error", {31'h0, error}, 32'h0);
        check("rst_err_cnt", {24'h0, err_cnt}, 32'h0);
        check("awsize", {29'h0, awsize}, 32'h2);
        check("awburst", {30'h0, awburst}, 32'h1);
        check("arcache", {28'h0, arcache}, 32'h2);
        check("wstrb", {28'h0, wstrb}, 32'hF);
        check("rst_len1_wlast", {31'h0, wlast1}, 32'h0);
        rst = 1'b0;

        run_seq("clean", 32'h0000_1000, 1'b0, 16'h0000, 2'b00, 1'b0, 8'd0);
        run_seq("bp", 32'hFFFF_FFF8, 1'b1, 16'h0000, 2'b00, 1'b0, 8'd0);
        run_seq("corrupt", 32'h0000_3000, 1'b0, 16'h0088, 2'b00, 1'b1, 8'd2);
        run_seq("slverr", 32'h0000_4000, 1'b0, 16'h0000, 2'b10, 1'b1, 8'd0);
        run_seq("cleared", 32'h0000_4100, 1'b1, 16'h0000, 2'b00, 1'b0, 8'd0);

        // Reset in the middle of the write burst.
        cur_seed = 32'h0000_5A00; bp = 1'b0; corrupt = '0; bresp_cfg = 2'b00;
        @(negedge clk);
        start = 1'b1; seed = cur_seed;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 200 && wbeat < 5; i++) begin
            @(negedge clk);
            #1;
        end
        check("midw_reached", {31'h0, wbeat >= 5}, 32'h1);
        #2 rst = 1'b1;
        #1;
        check("midw_wvalid", {31'h0, wvalid}, 32'h0);
        check("midw_busy", {31'h0, busy}, 32'h0);
        check("midw_wlast", {31'h0, wlast}, 32'h0);
        check("midw_wdata", wdata, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_seq("post_rst", 32'h0000_6000, 1'b0, 16'h0000, 2'b00, 1'b0, 8'd0);

        // Start requests during R and during DONE must be ignored.
        cur_seed = 32'h0000_7000;
        d0 = n_done;
        @(negedge clk);
        start = 1'b1; seed = cur_seed;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 500 && !rready; i++) @(negedge clk);
        check("ign_in_r", {31'h0, rready}, 32'h1);
        start = 1'b1; seed = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 500 && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        check("ign_done_seen", {31'h0, seen}, 32'h1);
        check("ign_error", {31'h0, error}, 32'h0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("ign_busy", {31'h0, busy}, 32'h0);
        check("ign_awvalid", {31'h0, awvalid}, 32'h0);
        check("ign_done_pulses", n_done - d0, 1);

        run_len1();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axi_burst_master.md
Name: axi_burst_master

Overview:
- AXI4 (full) master, the initiator counterpart of the team's AXI4 burst slave with internal RAM.
- On a start pulse it issues one INCR write burst of a known pattern (seed + beat index), takes the write response, then issues one INCR read burst to the same address and checks every returned beat.
- Reports busy, done, error and a mismatch count. Used as the on-chip traffic generator and self-checker for AXI slaves.

Parameters:
- C_M_TARGET_BASE_ADDR, 0, AWADDR/ARADDR value for both bursts.
- C_M_AXI_BURST_LEN, 16, beats per burst (1..256); AxLEN = value-1.
- C_M_AXI_ID_WIDTH, 1, AWID/ARID width; both IDs driven 0.
- C_M_AXI_ADDR_WIDTH, 32, address width.
- C_M_AXI_DATA_WIDTH, 32, data width (multiple of 8).
- C_M_AXI_AWUSER_WIDTH / ARUSER / WUSER / RUSER / BUSER, 1 each, user widths; outputs driven 0, inputs ignored.

Ports:
- M_AXI_ACLK  in  1  clock.
- M_AXI_ARESET  in  1  reset, asynchronous, active-high.
- i_start  in  1  one-cycle start request; accepted only in IDLE.
- i_seed  in  DATA_WIDTH  pattern seed, sampled when start is accepted.
- o_busy  out  1  high from start acceptance until DONE.
- o_done  out  1  one-cycle pulse at end of sequence.
- o_error  out  1  sticky error flag; cleared on next accepted start.
- o_err_cnt  out  8  data mismatch count, saturating at 255.
- M_AXI_AWID/AWADDR/AWLEN/AWVALID  out  ID/ADDR/8/1  write address channel; M_AXI_AWREADY  in  1.
- M_AXI_AWSIZE/AWBURST/AWLOCK/AWCACHE/AWPROT/AWQOS/AWREGION/AWUSER  out  3/2/1/4/3/4/4/AWUSER  constant: size=log2(DATA/8), burst=2'b01, cache=4'b0010, rest 0.
- M_AXI_WDATA/WSTRB/WLAST/WUSER/WVALID  out  DATA/DATA/8/1/WUSER/1  write data; M_AXI_WREADY  in  1.
- M_AXI_BID/BRESP/BUSER/BVALID  in  ID/2/BUSER/1  write response; M_AXI_BREADY  out  1.
- M_AXI_ARID/ARADDR/ARLEN/ARVALID + ARSIZE/ARBURST/ARLOCK/ARCACHE/ARPROT/ARQOS/ARREGION/ARUSER  out  as AW  read address, same constants; M_AXI_ARREADY  in  1.
- M_AXI_RID/RDATA/RRESP/RLAST/RUSER/RVALID  in  ID/DATA/2/1/RUSER/1  read data; M_AXI_RREADY  out  1.

Behaviour:
- Reset (async, immediate): FSM=IDLE; all VALID/READY outputs, o_busy, o_done, o_error, o_err_cnt, beat counters = 0; WDATA = 0, WLAST = 0. Reset mid-burst drops valids the same instant; no burst completion is attempted.
- FSM: IDLE -> AW (on i_start) -> W -> B -> AR -> R -> DONE -> IDLE. i_start outside IDLE is ignored.
- AW: AWVALID rises the cycle after entry and is held with AWADDR/AWLEN stable until AWREADY. On the handshake, AWVALID=0 next cycle and the FSM moves to W.
- W: WVALID is high from the first W cycle; beat k carries WDATA = seed + k (mod 2^DATA), WSTRB all ones, WLAST = (k == LEN-1). Data/last are held while WVALID & !WREADY; the beat advances only on handshake. The handshake with WLAST drops WVALID and moves to B. Latency with WREADY tied high: LEN consecutive beats.
- B: BREADY=1 until BVALID. BRESP != 2'b00 sets o_error. Then AR.
- AR: same rules as AW on the AR channel.
- R: RREADY=1 for the whole state. Each RVALID&RREADY beat k is compared with seed + k; a mismatch increments o_err_cnt (saturating) and sets o_error. RRESP != 0 sets o_error. RLAST on a beat other than k = LEN-1 sets o_error. The state ends after the LEN-th accepted beat regardless of RLAST, then RREADY=0.
- DONE: o_done=1 for one cycle, o_busy=0 the same cycle, then IDLE.
- An accepted start clears o_error/o_err_cnt and captures the seed. AW and AR are never outstanding simultaneously.
- LEN=1: the single beat has WLAST=1 on its first cycle.

Decomposition:
- Shared package axi_pkg: BURST_INCR/FIXED/WRAP, RESP_OKAY/EXOKAY/SLVERR/DECERR, a size-from-width function, and the FSM state encoding.
- One sub-module, axi_beat_pattern: beat counter, seed+k generator, last flag and saturating mismatch counter. Instantiated once for W (generate) and once for R (check).

Test Plan:
- Loopback with the team's AXI RAM slave, LEN=16, seed=0x1000 -> 16 W beats 0x1000..0x100F, WLAST on beat 15, o_done pulse, o_error=0, o_err_cnt=0.
- Random WREADY/RREADY/AWREADY backpressure (50%) -> WDATA/WLAST/AWADDR stable while stalled; same result as above.
- Slave model corrupts read beat 3 and beat 7 -> o_err_cnt=2, o_error=1, o_done still pulses.
- BRESP=2'b10 (SLVERR) on the write -> o_error=1, read phase still runs, err_cnt=0.
- Reset asserted mid-W at beat 5 -> WVALID=0 and o_busy=0 immediately; a new start after reset runs a full clean sequence.
- i_start pulsed during R and held in DONE -> ignored; exactly one o_done. LEN=1 -> single beat with WLAST=1 and RLAST expected on beat 0.
